// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send inhibit, device-clocked
// shift-out of {parity, data}, acknowledge check and frame timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_SEND     = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_WAITIDLE = 3'd5;

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state;
  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [8:0]    shift;
  logic [3:0]    bit_cnt;
  logic          data_low;
  logic          ack_bad;

  logic fall;
  logic in_frame;
  logic tmo_hit;
  logic line_idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data_in;
      dat_s2   <= dat_s1;
    end
  end

  // Our own inhibit must never be mistaken for a device clock edge.
  assign fall      = clk_prev & ~clk_s2 & ~ps2_clk_oe;
  assign in_frame  = (state == S_SEND) || (state == S_ACK) || (state == S_WAITIDLE);
  assign tmo_hit   = in_frame && (tmo_cnt == TMO_LAST);
  assign line_idle = clk_s2 & dat_s2;

  assign tx_ready    = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_REQ);
  // Expiry releases data in the same cycle the error is flagged.
  assign ps2_data_oe = (state == S_REQ) || ((state == S_SEND) && data_low && !tmo_hit);
  assign done        = (state == S_WAITIDLE) && line_idle && !tmo_hit;
  assign ack_err     = done & ack_bad;
  assign timeout_err = tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      inh_cnt  <= '0;
      tmo_cnt  <= '0;
      shift    <= '0;
      bit_cnt  <= '0;
      data_low <= 1'b0;
      ack_bad  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          data_low <= 1'b0;
          if (tx_valid) begin
            shift   <= {~^tx_data, tx_data};
            inh_cnt <= '0;
            ack_bad <= 1'b0;
            state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            state <= S_REQ;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end
        S_REQ: begin
          tmo_cnt  <= '0;
          bit_cnt  <= '0;
          data_low <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND, S_ACK, S_WAITIDLE: begin
          if (tmo_hit) begin
            data_low <= 1'b0;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            case (state)
              S_SEND: begin
                if (fall) begin
                  if (bit_cnt == 4'd9) begin
                    data_low <= 1'b0;
                    state    <= S_ACK;
                  end else begin
                    data_low <= ~shift[0];
                    shift    <= shift >> 1;
                    bit_cnt  <= bit_cnt + 1'b1;
                  end
                end
              end
              S_ACK: begin
                if (fall) begin
                  ack_bad <= dat_s2;
                  state   <= S_WAITIDLE;
                end
              end
              default: begin
                if (line_idle) begin
                  state <= S_IDLE;
                end
              end
            endcase
          end
        end
        default: begin
          data_low <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
